// File: rtl/sc_fir_sequencer.sv
// Sequencing controller for the stochastic-computing FIR accumulator: owns the
// tap delay line, runs one 2^N-cycle stochastic evaluation per sample and hands off the count.
module sc_fir_sequencer #(
    parameter int             N         = 12,
    parameter int             ORDER     = 18,
    parameter logic [N-1:0]   LFSR_SEED = N'(1),
    parameter logic [N-1:0]   LFSR_POLY = N'(12'h829)
) (
    input  logic           clock,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N:0]     in_data,
    output logic [N:0]     tap_out [0:ORDER],
    output logic           hwa_start,
    output logic [N-1:0]   sel_bits,
    output logic [N-1:0]   R_y,
    input  logic [N:0]     hwa_out,
    input  logic           hwa_done,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [N:0]     y_data,
    output logic           busy,
    output logic [1:0]     fsm_state,
    output logic           done_missing
);

    // Handshakes: a transfer happens on the rising edge where valid and ready
    // are both high; a source holds valid and data stable until that edge.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [N-1:0] SEL_LAST = '1;

    logic [1:0]   state;
    logic [N-1:0] sel_q;
    logic [N-1:0] lfsr_q;
    logic [N-1:0] lfsr_next;
    logic [N:0]   y_q;
    logic         miss_q;

    assign lfsr_next = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_POLY : '0);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sel_q  <= '1;
            lfsr_q <= LFSR_SEED;
            y_q    <= '0;
            miss_q <= 1'b0;
            for (int k = 0; k <= ORDER; k++) begin
                tap_out[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        tap_out[0] <= in_data;
                        for (int k = 1; k <= ORDER; k++) begin
                            tap_out[k] <= tap_out[k-1];
                        end
                        miss_q <= 1'b0;
                        state  <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    sel_q <= '0;
                    state <= S_RUN;
                end
                S_RUN: begin
                    lfsr_q <= lfsr_next;
                    // The last select value closes the evaluation whether or not
                    // the datapath raised done; a missing done is only flagged.
                    if (sel_q == SEL_LAST) begin
                        y_q    <= hwa_out;
                        miss_q <= ~hwa_done;
                        sel_q  <= '1;
                        state  <= S_HOLD;
                    end else begin
                        sel_q <= sel_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (y_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = (state == S_IDLE);
    assign hwa_start    = (state == S_CLEAR);
    assign y_valid      = (state == S_HOLD);
    assign busy         = (state != S_IDLE);
    assign sel_bits     = sel_q;
    assign R_y          = lfsr_q;
    assign y_data       = y_q;
    assign fsm_state    = state;
    assign done_missing = miss_q;

endmodule

// File: tb/tb_sc_fir_sequencer.sv
// Bench for sc_fir_sequencer: a datapath stub feeds hwa_out, and a reference model
// derived from the sequencing rules predicts taps, R_y and the captured counts.
module tb_sc_fir_sequencer;

    localparam int N     = 12;
    localparam int ORDER = 18;
    localparam int TAPS  = ORDER + 1;
    localparam int RUNC  = 1 << N;

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    // main instance (N=12)
    logic          in_valid, in_ready, hwa_start, hwa_done, y_valid, y_ready, busy, done_missing;
    logic [N:0]    in_data, hwa_out, y_data;
    logic [N:0]    tap_out [0:ORDER];
    logic [N-1:0]  sel_bits, R_y;
    logic [1:0]    fsm_state;

    sc_fir_sequencer #(.N(N), .ORDER(ORDER), .LFSR_SEED(12'h001), .LFSR_POLY(12'h829)) u_dut (
        .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tap_out(tap_out), .hwa_start(hwa_start), .sel_bits(sel_bits),
        .R_y(R_y), .hwa_out(hwa_out), .hwa_done(hwa_done), .y_valid(y_valid),
        .y_ready(y_ready), .y_data(y_data), .busy(busy), .fsm_state(fsm_state),
        .done_missing(done_missing)
    );

    // small instance (N=4) for the 20-sample delay-line walk
    logic          s_in_valid, s_in_ready, s_hwa_start, s_hwa_done, s_y_valid, s_busy, s_done_missing;
    logic [4:0]    s_in_data, s_hwa_out, s_y_data;
    logic [4:0]    s_tap_out [0:ORDER];
    logic [3:0]    s_sel_bits, s_R_y;
    logic [1:0]    s_fsm_state;
    logic          s_y_ready = 1'b1;

    sc_fir_sequencer #(.N(4), .ORDER(ORDER), .LFSR_SEED(4'h1), .LFSR_POLY(4'hC)) u_small (
        .clock(clock), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .tap_out(s_tap_out), .hwa_start(s_hwa_start), .sel_bits(s_sel_bits),
        .R_y(s_R_y), .hwa_out(s_hwa_out), .hwa_done(s_hwa_done), .y_valid(s_y_valid),
        .y_ready(s_y_ready), .y_data(s_y_data), .busy(s_busy), .fsm_state(s_fsm_state),
        .done_missing(s_done_missing)
    );
    assign s_hwa_out  = 5'd0;
    assign s_hwa_done = (s_sel_bits == 4'hF);

    // datapath stub: one stochastic bit per select value, tap chosen by select
    logic [N:0] acc;
    always @(posedge clock) begin
        if (hwa_start)
            acc <= '0;
        else if (sel_bits != 12'hFFF)
            acc <= acc + ((tap_out[int'(sel_bits) % TAPS] > {1'b0, R_y}) ? 13'd1 : 13'd0);
    end
    assign hwa_out  = acc;
    assign hwa_done = (sel_bits == 12'hFFF);

    // ---------------- reference model / scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [N:0]   ref_tap [TAPS];
    logic [4:0]   s_ref_tap [TAPS];
    logic [N-1:0] lfsr_ref;
    logic [N-1:0] ry_exp [RUNC];
    logic [N-1:0] ry_hist [$];
    logic [N:0]   exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] s);
        return (s >> 1) ^ (s[0] ? 12'h829 : 12'h000);
    endfunction

    function automatic int tap_diffs();
        int d = 0;
        for (int k = 0; k < TAPS; k++) if (tap_out[k] !== ref_tap[k]) d++;
        return d;
    endfunction

    function automatic int s_tap_diffs();
        int d = 0;
        for (int k = 0; k < TAPS; k++) if (s_tap_out[k] !== s_ref_tap[k]) d++;
        return d;
    endfunction

    // Accept a sample, predict the whole evaluation, then check it cycle by cycle.
    // Entered and left on a negative edge; bp > 0 stalls y_ready that many cycles.
    task automatic do_sample(input logic [N:0] d, input int bp, input bit keep_valid,
                             input logic [N:0] next_d);
        logic [N:0] exp_y;
        in_data  = d;
        in_valid = 1'b1;
        y_ready  = (bp == 0);
        check("accept_in_ready", in_ready, 1);
        @(negedge clock);
        for (int k = TAPS - 1; k > 0; k--) ref_tap[k] = ref_tap[k-1];
        ref_tap[0] = d;
        exp_y = '0;
        for (int k = 0; k < RUNC; k++) begin
            ry_exp[k] = lfsr_ref;
            if (k < RUNC - 1 && ref_tap[k % TAPS] > {1'b0, lfsr_ref}) exp_y++;
            lfsr_ref = lfsr_step(lfsr_ref);
        end
        exp_q.push_back(exp_y);
        in_valid = keep_valid;
        if (keep_valid) in_data = next_d;
        check("clear_hwa_start", hwa_start, 1);
        check("clear_sel", sel_bits, 12'hFFF);
        check("clear_in_ready", in_ready, 0);
        check("clear_busy", busy, 1);
        check("clear_taps", tap_diffs(), 0);
        for (int c = 0; c < RUNC; c++) begin
            @(negedge clock);
            check("run_hwa_start", hwa_start, 0);
            check("run_sel", sel_bits, c);
            check("run_ry", R_y, ry_exp[c]);
            check("run_ry_nonzero", R_y != 0, 1);
            check("run_taps", tap_diffs(), 0);
            check("run_y_valid", y_valid, 0);
            check("run_in_ready", in_ready, 0);
            if (c == RUNC - 1) check("run_done", hwa_done, 1);
            ry_hist.push_back(R_y);
            if (ry_hist.size() > RUNC - 1) begin
                check("ry_period", R_y, ry_hist[0]);
                void'(ry_hist.pop_front());
            end
        end
        @(negedge clock);
        exp_y = exp_q.pop_front();
        check("hold_y_valid", y_valid, 1);
        check("hold_y_data", y_data, exp_y);
        check("hold_sel", sel_bits, 12'hFFF);
        check("hold_done_missing", done_missing, 0);
        for (int b = 0; b < bp; b++) begin
            @(negedge clock);
            check("bp_y_valid", y_valid, 1);
            check("bp_y_data", y_data, exp_y);
            check("bp_in_ready", in_ready, 0);
            check("bp_taps", tap_diffs(), 0);
        end
        y_ready = 1'b1;
        @(negedge clock);
        check("post_y_valid", y_valid, 0);
        check("post_in_ready", in_ready, 1);
        check("post_busy", busy, 0);
        check("post_taps", tap_diffs(), 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [N:0] d3, d4;
        in_valid = 1'b0; in_data = '0; y_ready = 1'b1;
        s_in_valid = 1'b0; s_in_data = '0;
        lfsr_ref = 12'h001;
        for (int k = 0; k < TAPS; k++) begin ref_tap[k] = '0; s_ref_tap[k] = '0; end

        // reset and idle
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_sel", sel_bits, 12'hFFF);
        check("rst_ry", R_y, 12'h001);
        check("rst_y_valid", y_valid, 0);
        check("rst_y_data", y_data, 0);
        check("rst_hwa_start", hwa_start, 0);
        check("rst_busy", busy, 0);
        check("rst_taps", tap_diffs(), 0);

        // latency sample, then a back-to-back sample spanning the LFSR period
        do_sample(13'h0800, 0, 1'b0, '0);
        do_sample(13'($urandom_range(0, 4200)), 0, 1'b0, '0);

        // backpressure with in_valid held; next sample accepted right after release
        d3 = 13'($urandom_range(0, 4200));
        d4 = 13'($urandom_range(0, 4200));
        do_sample(d3, 50, 1'b1, d4);
        do_sample(d4, 0, 1'b0, '0);

        // delay line on the small instance: samples 1..20
        for (int i = 1; i <= 20; i++) begin
            s_in_data  = 5'(i);
            s_in_valid = 1'b1;
            check("s_accept_ready", s_in_ready, 1);
            @(negedge clock);
            s_in_valid = 1'b0;
            for (int k = TAPS - 1; k > 0; k--) s_ref_tap[k] = s_ref_tap[k-1];
            s_ref_tap[0] = 5'(i);
            if (i == 20) begin
                check("s_tap0", s_tap_out[0], 20);
                check("s_tap18", s_tap_out[18], 2);
            end
            for (int c = 0; c < 40 && !s_y_valid; c++) begin
                @(negedge clock);
                check("s_taps_frozen", s_tap_diffs(), 0);
            end
            check("s_y_valid_seen", s_y_valid, 1);
            check("s_y_data", s_y_data, 0);
            @(negedge clock);
        end

        // reset in the middle of a run
        in_data  = 13'($urandom_range(0, 4200));
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        for (int c = 0; c < 1100 && sel_bits != 12'd1000; c++) @(negedge clock);
        check("mid_sel_reached", sel_bits, 1000);
        rst_n = 1'b0;
        @(negedge clock);
        rst_n = 1'b1;
        for (int k = 0; k < TAPS; k++) ref_tap[k] = '0;
        lfsr_ref = 12'h001;
        ry_hist.delete();
        check("mid_in_ready", in_ready, 1);
        check("mid_busy", busy, 0);
        check("mid_sel", sel_bits, 12'hFFF);
        check("mid_ry", R_y, 12'h001);
        check("mid_taps", tap_diffs(), 0);
        check("mid_y_data", y_data, 0);
        for (int c = 0; c < 20; c++) begin
            check("mid_y_valid", y_valid, 0);
            check("mid_hwa_start", hwa_start, 0);
            @(negedge clock);
        end

        // evaluation after reset restarts from the seed
        do_sample(13'($urandom_range(0, 4200)), 0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sc_fir_sequencer.md
# sc_fir_sequencer

Sequencing controller for the stochastic-computing FIR accumulator (the `n`/`order`-parameterised HWA datapath). It accepts binary input samples over a valid/ready handshake and maintains the (ORDER+1)-tap delay line feeding the datapath. For each sample it runs one full 2^N-cycle stochastic evaluation, driving the datapath's start, select-bit counter and random-number stream. It captures the accumulated count when the datapath signals done and presents it downstream over a valid/ready handshake.

## Interface
- N, 12, stochastic resolution; select counter and R_y are N bits, samples and result are N+1 bits
- ORDER, 18, filter order; delay line holds ORDER+1 taps
- LFSR_SEED, 12'h001, LFSR reset value; must be nonzero
- LFSR_POLY, 12'h829, Galois mask for x^12+x^6+x^4+x+1
- clock  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  sequencer can accept a sample
- in_data  in  N+1  binary input sample
- tap_out  out  [N:0] x (ORDER+1)  unpacked array to datapath `in`; tap_out[0] is the newest sample
- hwa_start  out  1  to datapath `start`; clears its accumulator
- sel_bits  out  N  to datapath `sel_bits`
- R_y  out  N  to datapath `R_y`; equals the LFSR state
- hwa_out  in  N+1  datapath `out`
- hwa_done  in  1  datapath `done`
- y_valid  out  1  result valid
- y_ready  in  1  downstream accepts result
- y_data  out  N+1  captured accumulated count
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CLEAR, RUN, HOLD.
- IDLE:
  - in_ready=1, sel_bits=all-ones.
  - On in_valid&in_ready: shift the delay line (tap_out[k]<=tap_out[k-1], tap_out[0]<=in_data), then go to CLEAR.
- CLEAR (1 cycle):
  - hwa_start=1, sel_bits=all-ones.
  - Go to RUN with the select counter set to 0.
- RUN (2^N cycles):
  - sel_bits counts 0..2^N-1, incrementing by 1 per cycle.
  - LFSR advances every RUN cycle: state<=(state>>1) ^ (state[0] ? LFSR_POLY : 0).
  - On the cycle where sel_bits==2^N-1: y_data<=hwa_out. This is the sum of 2^N-1 stochastic bits, range 0..2^N-1.
  - In the same cycle go to HOLD and set sel_bits back to all-ones.
  - If sel_bits==2^N-1 but hwa_done==0, still capture and still go to HOLD; the bench flags this as a protocol error.
- HOLD:
  - y_valid=1; y_data is stable.
  - On y_valid&y_ready go to IDLE.
- Delay line, sel_bits and the LFSR change only as stated above; in particular the taps are frozen during CLEAR, RUN and HOLD.
- The LFSR is not reseeded between samples. It never reaches 0, so R_y is never 0.
- in_ready=0 outside IDLE; in_valid in those states is ignored and not lost (the source holds it).
- hwa_start=0 in every state except CLEAR.

## Timing
- Reset values (rst_n low at posedge):
  - state IDLE, tap_out all 0, sel_bits all-ones, LFSR=LFSR_SEED, y_data 0.
  - y_valid 0, hwa_start 0, busy 0, in_ready 1 (follows from IDLE).
- Reset mid-RUN or mid-HOLD aborts the evaluation and drops any pending result; taps are cleared.
- Accept at edge T:
  - CLEAR during cycle T+1.
  - RUN cycles T+2..T+2^N+1.
  - y_valid high from cycle T+2^N+2.
  - Latency is 2^N+2 cycles (4098 at N=12).
- Handshake completes at edge H. IDLE (in_ready=1) from cycle H+1. A sample presented then is accepted at edge H+1, so the minimum period between results is 2^N+3 cycles.
- y_ready held low: y_valid and y_data hold indefinitely. No new sample is accepted and the taps do not shift.
- sel_bits wraps only through the HOLD transition and never wraps within RUN.
- hwa_out width N+1: the count 2^N-1 fits, so no saturation is needed.

## Test plan
- Reset and idle:
  - Stimulus: hold rst_n low 3 cycles, then release.
  - Required: in_ready=1, sel_bits=12'hFFF, R_y=12'h001, y_valid=0, all taps 0.
- Single sample latency:
  - Stimulus: in_data=13'h0800 with in_valid at edge T, y_ready=1.
  - Required: hwa_start high only in cycle T+1; sel_bits 0..4095 over T+2..T+4097; y_valid at T+4098; y_data equals a behavioral HWA model's count.
- Delay line:
  - Stimulus: feed 20 samples 1..20.
  - Required: after the 20th accept, tap_out[0]=20, tap_out[18]=2; taps unchanged during each RUN.
- LFSR period:
  - Stimulus: run two back-to-back samples (8192 RUN cycles).
  - Required: R_y never 0, and R_y repeats with period exactly 4095 (R_y at RUN cycle k+4095 equals R_y at RUN cycle k).
- Backpressure:
  - Stimulus: y_ready=0 for 50 cycles after y_valid, with in_valid held high.
  - Required: y_data stable, in_ready=0, no tap shift; the next sample is accepted 1 cycle after y_ready rises.
- Reset mid-run:
  - Stimulus: assert rst_n=0 at sel_bits=1000.
  - Required: IDLE next cycle, y_valid never asserted, taps 0, LFSR reloaded to 12'h001.
